iter_divider: RTL and testbench

//  Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) in the EXE stage. Producer of the
//  div_running status consumed by the stall/flush controller: while div_running is high,
//  IF/ID/EXE stall and MEM gets a bubble. One quotient bit per cycle; RISC-V special

---
 rtl/iter_divider.sv | 130 +++++++++++++
 tb/tb_iter_divider.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the EXE stage.
// Produces one quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             hold,
  input  logic             abort,
  output logic             div_running,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rem_q, dq_q, dvs_q;
  logic             rem_op_q, neg_quo_q, neg_rem_q;

  logic             acc, special, step, load_op;
  logic             is_signed, a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] abs_a, abs_b, special_res;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff_w, rem_nx, dq_nx, quo_fix, rem_fix, fin;

  assign acc       = (state_q == S_IDLE) & start & ~hold & ~abort;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & dividend[WIDTH-1];
  assign b_neg     = is_signed & divisor[WIDTH-1];
  assign abs_a     = a_neg ? -dividend : dividend;
  assign abs_b     = b_neg ? -divisor  : divisor;
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed & (dividend == MOST_NEG) & (divisor == '1);
  assign special   = div_zero | ovf;

  always_comb begin
    special_res = '1;
    if (div_zero)
      special_res = op[1] ? dividend : '1;
    else if (ovf)
      special_res = op[1] ? '0 : dividend;
  end

  // Restoring step: the partial remainder stays below the divisor, so a WIDTH-bit
  // modular difference is exact whenever the trial subtraction succeeds.
  assign shifted = {rem_q, dq_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign diff_w  = shifted[WIDTH-1:0] - dvs_q;
  assign rem_nx  = ge ? diff_w : shifted[WIDTH-1:0];
  assign dq_nx   = {dq_q[WIDTH-2:0], ge};
  assign quo_fix = neg_quo_q ? -dq_nx : dq_nx;
  assign rem_fix = neg_rem_q ? -rem_nx : rem_nx;
  assign fin     = rem_op_q ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (acc) state_d = special ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (abort)             state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_DONE;
      end
      S_DONE: if (!hold || abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_running = acc | ((state_q == S_BUSY) & ~abort);
    done        = (state_q == S_DONE);
  end

  assign load_op = acc & ~special;
  assign step    = (state_q == S_BUSY) & ~abort;

  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    if (acc) begin
      if (special) result_d = special_res;
      else         cnt_d    = CW'(WIDTH-1);
    end else if (step) begin
      if (cnt_q == '0) result_d = fin;
      else             cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_op) begin
      rem_q     <= '0;
      dq_q      <= abs_a;
      dvs_q     <= abs_b;
      rem_op_q  <= op[1];
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (step) begin
      rem_q <= rem_nx;
      dq_q  <= dq_nx;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed RV32M cases, hold/abort/reset control
// behaviour, and randomized operations compared to an arithmetic reference model.
module tb_iter_divider;

  logic        clk, nrst, start, hold, abort;
  logic [1:0]  op;
  logic [31:0] dividend, divisor;
  logic        div_running, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor), .hold(hold), .abort(abort),
    .div_running(div_running), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RISC-V M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one operation from IDLE and returns observations; ends in IDLE after DONE exits.
  task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int run, output logic acc_run, output logic [31:0] res);
    op = o; dividend = a; divisor = b; start = 1'b1;
    #1 acc_run = div_running;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; run = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin lat = k; break; end
      if (div_running) run++;
      @(posedge clk); #1;
    end
    res = result;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0;
    #1;
    checks++; if (div_running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", div_running); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_running !== 1'b0) begin failures++; $display("FAIL post_reset_idle done=%b running=%b exp=0,0", done, div_running); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [31:0] exp [8];
    int          lats[8];
    int lat, run;
    logic acc_run;
    logic [31:0] res;
    ops = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};
    as  = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd7, 32'd2, 32'd2, 32'd16, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd15, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    lats = '{33, 33, 33, 33, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      do_div(ops[i], as[i], bs[i], lat, run, acc_run, res);
      checks++; if (res !== exp[i]) begin failures++; $display("FAIL directed%0d_result got=%h exp=%h", i, res, exp[i]); end
      checks++; if (lat != lats[i]) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, lats[i]); end
      checks++; if (run != lats[i] - 1) begin failures++; $display("FAIL directed%0d_busy_cycles got=%0d exp=%0d", i, run, lats[i] - 1); end
      checks++; if (acc_run !== 1'b1) begin failures++; $display("FAIL directed%0d_accept_running got=%b exp=1", i, acc_run); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] r0;
    op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; hold = 1'b1;
    #1;
    checks++; if (div_running !== 1'b0) begin failures++; $display("FAIL hold_block_running got=%b exp=0", div_running); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_running !== 1'b0) begin failures++; $display("FAIL hold_no_accept done=%b running=%b exp=0,0", done, div_running); end
    hold = 1'b0;
    #1;
    checks++; if (div_running !== 1'b1) begin failures++; $display("FAIL hold_release_accept got=%b exp=1", div_running); end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL hold_done_reached got=%b exp=1", done); end
    hold = 1'b1; start = 1'b1;
    r0 = result;
    checks++; if (r0 !== 32'd10) begin failures++; $display("FAIL hold_result got=%h exp=0000000a", r0); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b1 || result !== r0 || div_running !== 1'b0) begin
        failures++; $display("FAIL hold_done_stable%0d done=%b result=%h running=%b exp=1,%h,0", c, done, result, div_running, r0);
      end
    end
    start = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_running !== 1'b0) begin failures++; $display("FAIL hold_exit done=%b running=%b exp=0,0", done, div_running); end
  endtask

  task automatic test_abort();
    logic [31:0] r_prev;
    int seen;
    r_prev = result;
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    abort = 1'b1;
    #1;
    checks++; if (div_running !== 1'b0) begin failures++; $display("FAIL abort_running got=%b exp=0", div_running); end
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || div_running !== 1'b0 || result !== r_prev) begin
      failures++; $display("FAIL abort_idle done=%b running=%b result=%h exp=0,0,%h", done, div_running, result, r_prev);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    // abort while in IDLE must block acceptance
    start = 1'b1; abort = 1'b1;
    #1;
    checks++; if (div_running !== 1'b0) begin failures++; $display("FAIL abort_idle_block got=%b exp=0", div_running); end
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    #1;
    checks++; if (div_running !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle_no_accept running=%b done=%b exp=0,0", div_running, done); end
    // abort while in DONE (with hold) returns to IDLE and keeps the result
    op = 2'b11; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    hold = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    hold = 1'b0; abort = 1'b0;
    checks++; if (done !== 1'b0 || result !== 32'd6) begin failures++; $display("FAIL abort_in_done done=%b result=%h exp=0,00000006", done, result); end
  endtask

  task automatic test_async_reset();
    op = 2'b00; dividend = 32'd12345; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    nrst = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || div_running !== 1'b0 || result !== 32'd0) begin
      failures++; $display("FAIL async_reset done=%b running=%b result=%h exp=0,0,00000000", done, div_running, result);
    end
    #3 nrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_running !== 1'b0) begin failures++; $display("FAIL async_reset_release done=%b running=%b exp=0,0", done, div_running); end
  endtask

  task automatic test_back_to_back();
    int lat, run;
    logic acc_run;
    logic [31:0] res;
    do_div(2'b00, 32'hFFFF_FF9C, 32'd7, lat, run, acc_run, res);
    checks++; if (res !== 32'hFFFF_FFF2 || lat != 33) begin failures++; $display("FAIL b2b_first result=%h lat=%0d exp=fffffff2,33", res, lat); end
    do_div(2'b01, 32'hFFFF_FFF0, 32'd3, lat, run, acc_run, res);
    checks++; if (acc_run !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", acc_run); end
    checks++; if (res !== 32'h5555_5550 || lat != 33) begin failures++; $display("FAIL b2b_second result=%h lat=%0d exp=55555550,33", res, lat); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      4:       return -($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int lat, run;
    logic acc_run;
    logic [31:0] res, a, b, e;
    logic [1:0] o;
    int el;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      e = ref_result(o, a, b);
      el = ref_latency(o, a, b);
      do_div(o, a, b, lat, run, acc_run, res);
      checks++; if (res !== e) begin failures++; $display("FAIL random%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, res, e); end
      checks++; if (lat != el) begin failures++; $display("FAIL random%0d_latency op=%0d a=%h b=%h got=%0d exp=%0d", i, o, a, b, lat, el); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
